// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter and the detector family.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } seq_tx_state_t;

    localparam logic       IDLE_BIT     = 1'b0;
    localparam logic [3:0] SEQ_PAT_1100 = 4'b1100;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB first, with load priority over shift.
module piso_shift_reg #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PAT_W-1:0] load_data,
    input  logic             shift_en,
    output logic             msb
);

    logic [PAT_W-1:0] data;

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift_en) begin
            data <= {data[PAT_W-2:0], 1'b0};
        end
    end

    assign msb = data[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first `reps` times with idle gaps.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a start handshake, start_ready high
// SEND    | a pattern bit is on x with x_valid high
// GAP     | idle gap between repeats, busy high, x_valid low
// DONE    | one-cycle done (and aborted) pulse, then back to IDLE
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W      = 4,
    parameter int CNT_W      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int IDX_W = $clog2(PAT_W);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_tx_state_t    state, state_next;
    logic [IDX_W-1:0] bit_idx;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_left;
    logic [GAP_W-1:0] gap_cnt;
    logic [PAT_W-1:0] pat_reg;
    logic [PAT_W-1:0] load_src;

    logic accept;
    logic last_bit;
    logic abort_hit;
    logic sh_load;
    logic sh_shift;
    logic sh_msb;
    logic x_next;

    assign start_ready = (state == ST_IDLE) && !rst;
    assign accept      = start_valid && start_ready;
    assign last_bit    = (bit_idx == IDX_LAST);
    assign rep_left    = rep_cnt - CNT_W'(1);
    assign abort_hit   = abort && ((state == ST_SEND) || (state == ST_GAP));
    assign load_src    = accept ? pattern : pat_reg;

    // The shifter runs one bit ahead of x: it holds the bits still to be sent,
    // while the current bit already sits in the x output register.
    piso_shift_reg #(
        .PAT_W(PAT_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .load_data({load_src[PAT_W-2:0], 1'b0}),
        .shift_en (sh_shift),
        .msb      (sh_msb)
    );

    always_comb begin
        state_next = state;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    sh_load    = 1'b1;
                    state_next = (reps != '0) ? ST_SEND : ST_DONE;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_next = ST_DONE;
                end else if (last_bit) begin
                    if (rep_left == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        sh_load    = 1'b1;
                        state_next = (GAP_CYCLES == 0) ? ST_SEND : ST_GAP;
                    end
                end else begin
                    sh_shift = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_next = ST_DONE;
                end else if (gap_cnt == '0) begin
                    state_next = ST_SEND;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // First bit of a rep comes from the pattern source; later bits from the shifter.
    always_comb begin
        x_next = IDLE_BIT;
        if (state_next == ST_SEND) begin
            if ((state == ST_SEND) && !last_bit) begin
                x_next = sh_msb;
            end else begin
                x_next = load_src[PAT_W-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            pat_reg <= '0;
        end else begin
            if (accept) begin
                pat_reg <= pattern;
                rep_cnt <= reps;
            end else if ((state == ST_SEND) && last_bit && !abort) begin
                rep_cnt <= rep_left;
            end

            if ((state == ST_SEND) && !last_bit && !abort) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end else begin
                bit_idx <= '0;
            end

            if ((state == ST_SEND) && (state_next == ST_GAP)) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            x       <= x_next;
            x_valid <= (state_next == ST_SEND);
            busy    <= (state_next == ST_SEND) || (state_next == ST_GAP);
            done    <= (state_next == ST_DONE);
            aborted <= abort_hit;
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx with a bit/done scoreboard checked at the falling edge.
module tb_seq_pattern_tx;
    import seq_pkg::*;

    localparam int PAT_W = 4;
    localparam int CNT_W = 4;
    localparam int GAP   = 1;

    typedef struct {
        int   cyc;
        logic ab;
    } done_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;
    logic             aborted;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    logic  exp_bits[$];
    done_t done_q[$];

    seq_pattern_tx #(
        .PAT_W     (PAT_W),
        .CNT_W     (CNT_W),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .pattern    (pattern),
        .reps       (reps),
        .abort      (abort),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every valid bit and every done pulse must match a queued expectation.
    logic  mon_bit;
    done_t mon_done;
    always @(negedge clk) begin
        if (x_valid === 1'b1) begin
            chk("bit_expected", exp_bits.size() != 0, 1);
            if (exp_bits.size() != 0) begin
                mon_bit = exp_bits.pop_front();
                chk("x_bit", x, mon_bit);
            end
        end else begin
            chk("x_idle", x, IDLE_BIT);
        end
        if (done === 1'b1) begin
            chk("done_expected", done_q.size() != 0, 1);
            if (done_q.size() != 0) begin
                mon_done = done_q.pop_front();
                chk("done_cycle", cyc, mon_done.cyc);
                chk("aborted_flag", aborted, mon_done.ab);
            end
        end else begin
            chk("aborted_without_done", aborted, 0);
        end
    end

    task automatic run_req(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] r,
                           input int abort_off, input logic abort_hs);
        int   k;
        int   doff;
        int   lim;
        int   per;
        logic ab;
        per = PAT_W + GAP;
        ab  = (abort_off >= 0);
        if (r == 0) doff = 0;
        else        doff = int'(r) * PAT_W + (int'(r) - 1) * GAP;
        if (ab) begin
            lim  = abort_off + 1;
            doff = abort_off + 1;
        end else begin
            lim = doff;
        end
        @(negedge clk);
        chk("ready_before", start_ready, 1);
        start_valid = 1'b1;
        pattern     = pat;
        reps        = r;
        abort       = abort_hs;
        for (int o = 0; o < lim; o++) begin
            if ((o % per) < PAT_W) exp_bits.push_back(pat[PAT_W-1-(o % per)]);
        end
        @(posedge clk);
        #1;
        k           = cyc;
        start_valid = 1'b0;
        abort       = 1'b0;
        pattern     = ~pat;
        reps        = ~r;
        done_q.push_back('{k + doff, ab});
        if (ab) begin
            do @(negedge clk); while (cyc < k + abort_off);
            abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
        end
        do @(negedge clk); while (cyc < k + doff);
        chk("xv_at_done", x_valid, 0);
        chk("ready_at_done", start_ready, 0);
        @(negedge clk);
        chk("ready_after_done", start_ready, 1);
        chk("busy_after_done", busy, 0);
        chk("bits_drained", exp_bits.size(), 0);
        chk("done_drained", done_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst         = 1'b1;
        start_valid = 1'b0;
        pattern     = '0;
        reps        = '0;
        abort       = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_x", x, 0);
        chk("rst_x_valid", x_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_ready", start_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", start_ready, 1);

        run_req(SEQ_PAT_1100, 4'd1, -1, 1'b0);
        run_req(SEQ_PAT_1100, 4'd3, -1, 1'b0);
        run_req(4'b1010, 4'd0, -1, 1'b0);
        run_req(SEQ_PAT_1100, 4'd2, 7, 1'b0);   // abort on bit 2 of rep 1
        run_req(4'b1011, 4'd2, 4, 1'b0);        // abort during the gap
        run_req(4'b0110, 4'd1, -1, 1'b1);       // abort with handshake is a normal accept
        run_req(4'b1001, 4'd15, -1, 1'b0);

        // start_valid held high across a transmission while inputs change
        @(negedge clk);
        chk("hold_ready", start_ready, 1);
        start_valid = 1'b1;
        pattern     = 4'b1010;
        reps        = 4'd1;
        exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b0);
        exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b0);
        @(posedge clk);
        #1;
        k = cyc;
        done_q.push_back('{k + 4, 1'b0});
        pattern = 4'b0101;
        reps    = 4'd2;
        do begin
            @(negedge clk);
            if (cyc < k + 5) chk("no_reaccept", start_ready, 0);
        end while (cyc < k + 5);
        chk("reaccept_ready", start_ready, 1);
        exp_bits.push_back(1'b0);
        exp_bits.push_back(1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("second_busy", busy, 1);
        @(negedge clk);
        rst         = 1'b1;
        start_valid = 1'b0;
        @(negedge clk);
        chk("midrst_x", x, 0);
        chk("midrst_x_valid", x_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_aborted", aborted, 0);
        chk("midrst_ready", start_ready, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_ready", start_ready, 1);
        chk("post_rst_bits", exp_bits.size(), 0);
        chk("post_rst_done", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
